uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmit serializer; downstream consumer of the clock divider output.
//   Runs on the divided TX bit clock: one bit period = one clk cycle.
//   Accepts a parallel word with a single-cycle valid strobe.
//   Emits a start bit, DATA_WIDTH data bits LSB-first, an optional parity bit
//   and one stop bit on tx_out. Reports busy while a frame is in flight.
// PARAMETERS
//   DATA_WIDTH  8  width of p_data; number of data bits per frame (>=1)
// PORTS
//   clk         in   1           TX bit clock (divided clock)
//   rst         in   1           asynchronous, active-high reset
//   p_data      in   DATA_WIDTH  parallel word to send
//   data_valid  in   1           p_data valid; sampled only when idle
//   par_en      in   1           1 = append parity bit
//   par_typ     in   1           0 = even parity, 1 = odd parity
//   tx_out      out  1           serial line; idles high
//   busy        out  1           1 while a frame is being sent
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, tx_out=1, busy=0, shift reg and counter=0.
// - tx_out and busy are registered; there is no combinational path from inputs.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
// - Transitions:
//     IDLE   -> START  on the edge where data_valid=1
//     START  -> DATA   after 1 cycle
//     DATA   -> PARITY after DATA_WIDTH cycles, if the latched par_en=1
//     DATA   -> STOP   after DATA_WIDTH cycles, if the latched par_en=0
//     PARITY -> STOP   after 1 cycle
//     STOP   -> IDLE   after 1 cycle
// - Acceptance edge (IDLE, data_valid=1):
//     latch p_data, par_en and par_typ
//     tx_out<=0 (start bit), busy<=1
// - data_valid is ignored in every state other than IDLE. No queuing.
// - Inputs changing mid-frame have no effect on the frame in flight.
// - DATA state:
//     tx_out = latched bit i, i = 0..DATA_WIDTH-1, LSB first
//     bit counter is $clog2(DATA_WIDTH)+1 bits wide; it clears on entry to DATA
// - PARITY state:
//     even: tx_out = ^data_latched
//     odd:  tx_out = ~^data_latched
// - STOP state: tx_out=1, busy stays 1.
// - Return to IDLE: busy<=0, tx_out stays 1.
//     Minimum of one IDLE cycle between frames.
//     Back-to-back throughput: one frame per (frame length + 1) cycles.
// - Frame length = 2 + DATA_WIDTH + par_en cycles.
//     busy is high for exactly this many cycles.
// - Reset asserted mid-frame aborts immediately:
//     tx_out=1, busy=0
//     no partial frame resumes after reset is released
// - data_valid=1 on the first edge after reset release is accepted normally.
// TESTING
// 1. Reset: rst=1 with random inputs -> tx_out=1, busy=0; both hold through 3 idle cycles.
// 2. p_data=8'hA5, par_en=0:
//    tx_out per cycle = 0,1,0,1,0,0,1,0,1,1
//    busy=1 for exactly 10 cycles, then tx_out=1
// 3. p_data=8'hA5, par_en=1, par_typ=0 (even): parity bit=0, 11-cycle frame.
//    p_data=8'h01, par_typ=0 -> parity bit=1.
//    p_data=8'h01, par_typ=1 (odd) -> parity bit=0.
// 4. Pulse data_valid with 8'h3C while a frame of 8'hA5 is in flight:
//    8'h3C is dropped; only the 8'hA5 frame appears.
//    Then hold data_valid=1 continuously -> frames separated by exactly 1 idle-high cycle.
// 5. Assert rst during data bit 3 of 8'hFF:
//    tx_out=1 and busy=0 immediately, without waiting for a clk edge.
//    After release with data_valid=1 and 8'h00 -> clean full frame 0,0x8,1.
// 6. Change p_data/par_en/par_typ every cycle during a frame -> serialized bits match the values latched at acceptance.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer running on the divided TX bit clock.
// Sends start, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
//
// Ports:
//   clk        - TX bit clock (one bit period per cycle)
//   rst        - asynchronous, active-high reset
//   p_data     - parallel word to send
//   data_valid - single-cycle strobe, only honoured while idle
//   par_en     - 1 = append a parity bit
//   par_typ    - 0 = even parity, 1 = odd parity
//   tx_out     - registered serial line, idles high
//   busy       - registered, high for every cycle of a frame
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;
    logic                  par_en_q;
    logic                  par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (data_valid) begin
                        state    <= START;
                        shreg    <= p_data;
                        par_en_q <= par_en;
                        // Parity is fixed by the word latched here, so
                        // resolve it once instead of keeping a data copy.
                        par_bit  <= (^p_data) ^ par_typ;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    state  <= DATA;
                    cnt    <= '0;
                    tx_out <= shreg[0];
                    shreg  <= shreg >> 1;
                end

                DATA: begin
                    if (cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            tx_out <= par_bit;
                        end else begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        tx_out <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                end

                PARITY: begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                end

                STOP: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: randomized and directed frames
// scored against a frame-level reference model through an expected-bit queue.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Expected line value for each busy cycle, oldest first.
    bit q[$];
    // Bits seen on tx_out during the most recent busy window.
    bit cap[$];
    bit last_frame[$];
    int idle_run = 0;
    int last_gap = 0;
    bit prev_busy = 0;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack_frame();
        int v = 0;
        foreach (last_frame[i]) if (last_frame[i]) v |= (1 << i);
        return v;
    endfunction

    // Reference model: a frame is start, data LSB-first, optional parity
    // making the total ones count even/odd, then stop. After a frame of L
    // cycles the line needs one idle cycle before the next acceptance.
    task automatic push_frame(input logic [7:0] d, input bit en, input bit typ);
        int ones = $countones(d);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (en) q.push_back(typ ? (ones % 2 == 0) : (ones % 2 == 1));
        q.push_back(1'b1);
    endtask

    initial begin : model
        int left = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                left = 0;
            end else if (left == 0 && data_valid) begin
                push_frame(p_data, par_en, par_typ);
                left = 10 + int'(par_en);
            end else if (left > 0) begin
                left--;
            end
        end
    end

    initial begin : monitor
        bit exp_busy;
        bit exp_tx;
        forever begin
            @(negedge clk);
            exp_busy = (q.size() > 0);
            exp_tx = exp_busy ? q.pop_front() : 1'b1;
            chk("busy", int'(busy), int'(exp_busy));
            chk("tx_out", int'(tx_out), int'(exp_tx));
            if (busy) begin
                if (!prev_busy) begin
                    cap.delete();
                    last_gap = idle_run;
                end
                cap.push_back(tx_out);
                idle_run = 0;
            end else begin
                if (prev_busy) last_frame = cap;
                idle_run++;
            end
            prev_busy = busy;
        end
    end

    task automatic send(input logic [7:0] d, input bit en, input bit typ);
        @(negedge clk); #1;
        p_data = d;
        par_en = en;
        par_typ = typ;
        data_valid = 1'b1;
        @(negedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while ((busy || q.size() != 0) && n < 200);
        chk("wait_idle_timeout", int'(busy || q.size() != 0), 0);
    endtask

    initial begin : stim
        rst = 1'b1;
        data_valid = 1'($urandom);
        p_data = 8'($urandom);
        par_en = 1'($urandom);
        par_typ = 1'($urandom);

        // Reset with random inputs, then three idle cycles.
        repeat (3) begin
            @(negedge clk); #1;
            data_valid = 1'($urandom);
            p_data = 8'($urandom);
            par_en = 1'($urandom);
            par_typ = 1'($urandom);
            chk("reset_tx", int'(tx_out), 1);
            chk("reset_busy", int'(busy), 0);
        end
        data_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_tx", int'(tx_out), 1);
        chk("idle_busy", int'(busy), 0);

        // A5 without parity.
        send(8'hA5, 1'b0, 1'b0);
        wait_idle();
        chk("a5_len", last_frame.size(), 10);
        chk("a5_bits", pack_frame(), 'h34A);

        // Parity variants.
        send(8'hA5, 1'b1, 1'b0);
        wait_idle();
        chk("a5_even_len", last_frame.size(), 11);
        chk("a5_even_par", int'(last_frame[9]), 0);
        send(8'h01, 1'b1, 1'b0);
        wait_idle();
        chk("01_even_par", int'(last_frame[9]), 1);
        send(8'h01, 1'b1, 1'b1);
        wait_idle();
        chk("01_odd_par", int'(last_frame[9]), 0);

        // A strobe mid-frame is dropped.
        send(8'hA5, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        p_data = 8'h3C;
        data_valid = 1'b1;
        @(negedge clk); #1;
        data_valid = 1'b0;
        wait_idle();
        chk("drop_bits", pack_frame(), 'h34A);
        repeat (3) @(negedge clk);
        #1;
        chk("drop_no_frame", int'(busy), 0);

        // Continuous valid: one idle cycle between frames.
        @(negedge clk); #1;
        p_data = 8'hA5;
        par_en = 1'b0;
        data_valid = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        data_valid = 1'b0;
        wait_idle();
        chk("b2b_gap", last_gap, 1);

        // Asynchronous reset during data bit 3 of FF.
        send(8'hFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", int'(tx_out), 1);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk); #1;
        p_data = 8'h00;
        par_en = 1'b0;
        data_valid = 1'b1;
        rst = 1'b0;
        @(negedge clk); #1;
        data_valid = 1'b0;
        wait_idle();
        chk("post_rst_len", last_frame.size(), 10);
        chk("post_rst_bits", pack_frame(), 'h200);

        // Inputs churn every cycle while a frame is in flight.
        repeat (5) begin
            send(8'($urandom), 1'($urandom), 1'($urandom));
            repeat (12) begin
                p_data = 8'($urandom);
                par_en = 1'($urandom);
                par_typ = 1'($urandom);
                @(negedge clk); #1;
            end
            wait_idle();
        end

        // Random traffic.
        repeat (1500) begin
            @(negedge clk); #1;
            data_valid = ($urandom_range(3) == 0);
            p_data = 8'($urandom);
            par_en = 1'($urandom);
            par_typ = 1'($urandom);
        end
        data_valid = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
